// File: rtl/adffe_pipe.sv
// adffe_pipe: DEPTH-stage valid/ready pipeline of async-reset, enabled WIDTH-bit registers
// with bubble collapsing, global enable, synchronous flush; `count` output when ADFFE_PIPE_COUNT_EN is defined.
module adffe_pipe #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned DEPTH       = 3,
  parameter logic        EN_POLARITY = 1'b1,
  parameter int unsigned ARST_VALUE  = 2
) (
  input  logic             pos_clk,
  input  logic             pos_arst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef ADFFE_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  localparam logic [WIDTH-1:0] RST_D = WIDTH'(ARST_VALUE);

  logic [DEPTH-1:0]            r_v;
  logic [DEPTH-1:0][WIDTH-1:0] r_d;
  logic [DEPTH:0]              w_rdy;
  logic [DEPTH-1:0]            w_up_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_up_d;
  logic                        w_en_act;

  assign w_en_act = (en == EN_POLARITY);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
    if (gi == 0) begin : g_head
      assign w_up_v[gi] = in_valid;
      assign w_up_d[gi] = in_data;
    end else begin : g_body
      assign w_up_v[gi] = r_v[gi-1];
      assign w_up_d[gi] = r_d[gi-1];
    end
  end

  // Ready ripples from the output end back to stage 0 in one combinational block.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_rdy[DEPTH-1-k] = ~r_v[DEPTH-1-k] | w_rdy[DEPTH-k];
    end
  end

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      r_v <= '0;
      r_d <= {DEPTH{RST_D}};
    end else if (flush) begin
      r_v <= '0;
      r_d <= {DEPTH{RST_D}};
    end else if (w_en_act) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_up_v[k];
          if (w_up_v[k]) begin
            r_d[k] <= w_up_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_en_act & ~flush & ~pos_arst & w_rdy[0];
  assign out_valid = w_en_act & ~flush & r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];

`ifdef ADFFE_PIPE_COUNT_EN
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] r_count;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Tracks popcount(r_v) incrementally from the handshake events.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_xfer & ~w_out_xfer) begin
      r_count <= r_count + CNT_W'(1);
    end else if (~w_in_xfer & w_out_xfer) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count = r_count;
`endif

endmodule

// File: doc/adffe_pipe.md
Name: adffe_pipe

Overview:
- Parametrised successor to the single async-reset, enabled flop: a DEPTH-stage chain of WIDTH-bit async-reset, enabled registers.
- Each stage carries a valid bit, and the chain uses a valid/ready handshake with bubble collapsing.
- Adds a global enable, a synchronous flush and back-pressure.
- Used as a retiming / skid pipeline between blocks in the flop test-design set.

Parameters:
- WIDTH, 2, data width per stage (>=1).
- DEPTH, 3, number of register stages (>=1).
- EN_POLARITY, 1'b1, active level of en.
- ARST_VALUE, 2, data value loaded by pos_arst and by flush; truncated to WIDTH.

Ports:
- pos_clk  input  1  clock; all state updates on rising edge.
- pos_arst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; active when en == EN_POLARITY.
- flush  input  1  synchronous clear of the whole pipeline.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  out_data valid.
- out_data  output  WIDTH  data of last stage.
- out_ready  input  1  downstream accepts this cycle.

Behaviour:
- State: v[0..DEPTH-1] (valid bits) and d[0..DEPTH-1] (WIDTH-bit data). Stage 0 is the input end; stage DEPTH-1 drives the outputs.
- Asynchronous reset: pos_arst=1 forces all v=0 and all d=ARST_VALUE immediately, independent of pos_clk. Outputs under reset: in_ready=0, out_valid=0, out_data=ARST_VALUE.
- Enable: en_act = (en == EN_POLARITY).
- Ready chain (combinational): r[DEPTH]=out_ready; r[i] = !v[i] | r[i+1].
- in_ready = en_act & !flush & !pos_arst & r[0].
- out_valid = en_act & !flush & v[DEPTH-1]. out_data = d[DEPTH-1] at all times.
- in_ready depends combinationally on out_ready; this path is the full chain and is intended.
- At each rising pos_clk, priority order:
  1. pos_arst.
  2. flush=1: all v<=0, all d<=ARST_VALUE. Applies regardless of en; no transfer occurs in that cycle.
  3. !en_act: all state holds; no transfer in or out.
  4. Otherwise, for each stage i with r[i]=1: v[i] <= upstream valid, where upstream is in_valid for i=0, else v[i-1]. d[i] captures upstream data only if upstream valid is 1; otherwise d[i] holds its old value.
  5. Stages with r[i]=0 hold.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_valid=1 with in_ready=0: the item is not taken, and upstream must hold it.
- Latency, no stalls: an item accepted at edge N is on out_data with out_valid=1 from edge N+DEPTH-1. For DEPTH=1 this is immediately after the accepting edge.
- Throughput: 1 item/cycle sustained when out_ready=1.
- Bubbles: empty stages are filled by the stalled upstream while out_ready=0, so up to DEPTH items are stored.
- Full (all v=1) with out_ready=0: in_ready=0.
- Full with out_ready=1: in_ready=1, and simultaneous accept and emit occur in the same cycle.
- Ordering: strictly FIFO; no item is dropped or duplicated.
- Reset mid-operation: all in-flight items are discarded. flush mid-operation behaves the same, but synchronously.

Optional Feature:
- Macro: ADFFE_PIPE_COUNT_EN.
- Defined: extra output port `count`, width $clog2(DEPTH+1), holding the number of valid stages.
  - Reset and flush set it to 0.
  - +1 on input transfer only; -1 on output transfer only; unchanged on both or neither.
  - Must always equal popcount(v).
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=3, ARST_VALUE=8'h5A unless noted):
- Reset: assert pos_arst between clock edges -> out_data=8'h5A, out_valid=0 and in_ready=0 immediately, without waiting for an edge.
- Streaming: out_ready=1, push 8'h01, 8'h02, 8'h03 on consecutive edges N..N+2 -> out_valid=1 with out_data=8'h01 from edge N+2, then 8'h02, 8'h03 on the following edges.
- Back-pressure: out_ready=0, push 8'h10, 8'h11, 8'h12, 8'h13:
  - After the third accept, in_ready=0 and 8'h13 is held upstream.
  - Raise out_ready -> 8'h10..8'h13 emerge in order, with no loss.
- Enable: full pipeline, en=0 for 5 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0 and state unchanged. en=1 -> output resumes with the same data.
- Flush: flush=1 for one edge while full -> all stages clear, out_valid=0, out_data=8'h5A. The next push appears after 2 further edges.
- DEPTH=1 with ADFFE_PIPE_COUNT_EN defined -> count follows 0→1→1→0 across accept, simultaneous accept+emit, emit. Simultaneous accept+emit with full pipeline keeps count=1.
